button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the number of consecutive stable cycles required to accept a new button level (10 ms at 100 MHz); legal range 2 and up.
REQ-002 The block SHALL have parameter SW_WIDTH, default 4, giving the number of switch inputs.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port btn_raw, input, 1 bit: the asynchronous, bouncing push-button level (1 = pressed).
REQ-006 The block SHALL have port sw_raw, input, SW_WIDTH bits: the asynchronous slide-switch levels.
REQ-007 The block SHALL have port btn_level, output, 1 bit: the debounced button level.
REQ-008 The block SHALL have port btn_press, output, 1 bit: a one-cycle pulse on each accepted press.
REQ-009 The block SHALL have port btn_release, output, 1 bit: a one-cycle pulse on each accepted release.
REQ-010 The block SHALL have port sw_sync, output, SW_WIDTH bits: the synchronized switch levels.
REQ-011 The block SHALL have port sw_latched, output, SW_WIDTH bits: the sw_sync value captured on each accepted press.

Function
REQ-012 btn_raw and each sw_raw bit SHALL pass through a two-flop synchronizer; btn_sync and sw_sync lag raw inputs by exactly 2 cycles.
REQ-013 The FSM SHALL have states IDLE (released, stable), PRESS_WAIT, HELD (pressed, stable) and RELEASE_WAIT.
REQ-014 In IDLE, btn_sync=1 SHALL move the FSM to PRESS_WAIT with cnt=0; otherwise the FSM stays in IDLE.
REQ-015 In PRESS_WAIT, btn_sync=0 SHALL return the FSM to IDLE with cnt cleared (bounce rejected); btn_sync=1 with cnt==DEBOUNCE_CYCLES-1 SHALL move it to HELD; otherwise cnt increments.
REQ-016 HELD to RELEASE_WAIT and RELEASE_WAIT to IDLE/HELD SHALL mirror REQ-014/REQ-015 with the polarity of btn_sync inverted.
REQ-017 btn_level SHALL be 1 exactly while the FSM is in HELD or RELEASE_WAIT.
REQ-018 btn_press SHALL be 1 for exactly the first cycle after the PRESS_WAIT-to-HELD transition; btn_release SHALL be 1 for exactly the first cycle after the RELEASE_WAIT-to-IDLE transition; the two are never high together.
REQ-019 Latency: a clean raw edge held stable SHALL produce its pulse DEBOUNCE_CYCLES+3 cycles after the raw edge.
REQ-020 Any raw glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL produce no pulse and no btn_level change.
REQ-021 sw_latched SHALL load sw_sync in the same cycle btn_press is 1 and hold otherwise.
REQ-022 cnt SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL never wrap, because it clears on every state change.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL set the FSM to IDLE, cnt to 0, both synchronizer stages to 0, btn_level/btn_press/btn_release to 0, and sw_sync/sw_latched to all zeros.
REQ-024 Reset asserted during PRESS_WAIT or HELD SHALL discard the pending or held press without emitting btn_release.
REQ-025 After rst deasserts with btn_raw already 1, the block SHALL treat it as a new press (full debounce, then btn_press).

Structure
REQ-026 State encoding (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and the DEBOUNCE_CYCLES default constant SHALL live in shared package button_pkg.
REQ-027 The two-flop synchronizer SHALL be a separate width-parameterized sub-module sync_2ff, instantiated once for btn_raw and once for sw_raw.

Verification (DEBOUNCE_CYCLES=4, SW_WIDTH=4)
REQ-028 Reset: rst=1 for 2 cycles with btn_raw=1 and sw_raw=4'hF -> all outputs 0; after release, btn_press pulses 7 cycles later.
REQ-029 Clean press: btn_raw 0->1 at cycle t and held -> btn_press=1 at t+7 only; btn_level=1 from t+7.
REQ-030 Bounce: btn_raw toggles 1,0,1,0 over 4 cycles, then stays 0 -> no btn_press, btn_level stays 0.
REQ-031 Release: from HELD, btn_raw 1->0 at t and held -> btn_release=1 at t+7 only; btn_level=0 from t+7.
REQ-032 Latch: sw_raw=4'hA, then press; sw_raw changes to 4'h5 after btn_press -> sw_latched=4'hA, sw_sync=4'h5 two cycles after the change.
REQ-033 Reset mid-press: rst pulsed during PRESS_WAIT -> no btn_press, FSM back to IDLE, cnt=0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared constants for the push-button conditioner: FSM state encoding and
// the default debounce interval.
package button_pkg;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    localparam logic [1:0] ST_IDLE         = 2'd0;  // released, stable
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;  // candidate press, counting
    localparam logic [1:0] ST_HELD         = 2'd2;  // pressed, stable
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;  // candidate release, counting

    // The debounced level is high in both "pressed" states.
    function automatic logic is_pressed_state(input logic [1:0] st);
        return (st == ST_HELD) || (st == ST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs. Output lags the input
// by exactly two clk cycles; both stages clear on synchronous reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next-stage values: plain shift from raw input through both stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button debouncer with press/release pulses, plus switch synchronizers
// and a snapshot of the switches taken on every accepted press.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SW_WIDTH        = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic                btn_level,
    output logic                btn_press,
    output logic                btn_release,
    output logic [SW_WIDTH-1:0] sw_sync,
    output logic [SW_WIDTH-1:0] sw_latched
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; it clears on every
    // state change so it can never wrap.
    localparam int               CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic                btn_sync;
    logic [1:0]          state_q,   state_d;
    logic [CW-1:0]       cnt_q,     cnt_d;
    logic                level_q,   level_d;
    logic                press_q,   press_d;
    logic                release_q, release_d;
    logic [SW_WIDTH-1:0] latched_q, latched_d;

    sync_2ff #(.WIDTH(1)) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_sync)
    );

    sync_2ff #(.WIDTH(SW_WIDTH)) u_sync_sw (
        .clk (clk),
        .rst (rst),
        .d   (sw_raw),
        .q   (sw_sync)
    );

    // Debounce FSM: a level change is accepted only after btn_sync has held
    // the new value through a full count; any reversion restarts from stable.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        latched_d = latched_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_sync) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HELD: begin
                if (!btn_sync) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Snapshot switches on the accepted press so it is visible alongside btn_press.
        if (press_d) begin
            latched_d = sw_sync;
        end
        level_d = is_pressed_state(state_d);
    end

    // State and registered outputs; reset discards any pending/held press silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            latched_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            latched_q <= latched_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign sw_latched  = latched_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios followed by random bouncy
// stimulus, every cycle compared against a run-length debounce model.
module tb_button_conditioner;
    import button_pkg::*;

    localparam int D = 4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_raw;
    logic [W-1:0] sw_raw;
    logic         btn_level, btn_press, btn_release;
    logic [W-1:0] sw_sync, sw_latched;

    button_conditioner #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .sw_raw      (sw_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .sw_sync     (sw_sync),
        .sw_latched  (sw_latched)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: raw inputs reach the debouncer through a 2-entry delay
    // line; a new level is accepted once the delayed input has disagreed with
    // the current level on D+1 consecutive edges.
    logic         bq[$];
    logic [W-1:0] sq[$];
    logic         m_level, m_press, m_rel;
    logic [W-1:0] m_swsync, m_latched;
    int           m_run;

    int seen, npress, nlevel, hold;
    logic         rb;
    logic [W-1:0] rs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        bq.delete(); bq.push_back(1'b0); bq.push_back(1'b0);
        sq.delete(); sq.push_back('0);   sq.push_back('0);
        m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
        m_swsync = '0;  m_latched = '0; m_run = 0;
    endtask

    // One clock: drive, update model at the edge, compare at the falling edge.
    task automatic cyc(input logic b, input logic [W-1:0] s, input logic r);
        logic         cur_b;
        logic [W-1:0] cur_s;
        btn_raw = b;
        sw_raw  = s;
        rst     = r;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            cur_b = bq[0];
            cur_s = sq[0];
            void'(bq.pop_front()); bq.push_back(b);
            void'(sq.pop_front()); sq.push_back(s);
            m_swsync = sq[0];
            m_press = 1'b0;
            m_rel   = 1'b0;
            if (cur_b != m_level) m_run++;
            else                  m_run = 0;
            if (m_run == D + 1) begin
                m_level = ~m_level;
                m_run   = 0;
                m_press = m_level;
                m_rel   = ~m_level;
                if (m_press) m_latched = cur_s;
            end
        end
        @(negedge clk);
        check("btn_level",   32'(btn_level),   32'(m_level));
        check("btn_press",   32'(btn_press),   32'(m_press));
        check("btn_release", 32'(btn_release), 32'(m_rel));
        check("sw_sync",     32'(sw_sync),     32'(m_swsync));
        check("sw_latched",  32'(sw_latched),  32'(m_latched));
        check("press_and_release", 32'(btn_press & btn_release), 32'(0));
    endtask

    initial begin
        model_reset();
        btn_raw = 1'b0; sw_raw = '0; rst = 1'b1;
        @(negedge clk);

        // Reset with button held and switches all on: outputs stay low.
        cyc(1'b1, 4'hF, 1'b1);
        cyc(1'b1, 4'hF, 1'b1);
        check("rst_level",   32'(btn_level),   32'(0));
        check("rst_press",   32'(btn_press),   32'(0));
        check("rst_sw_sync", 32'(sw_sync),     32'(0));
        check("rst_latched", 32'(sw_latched),  32'(0));
        check("rst_state",   32'(dut.state_q), 32'(ST_IDLE));

        // Button already down at reset release: treated as a fresh press.
        seen = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 4'hF, 1'b0);
            if (btn_press && seen == 0) seen = i;
        end
        check("post_rst_press_latency", 32'(seen), 32'(7));

        // Clean release.
        seen = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, 4'hF, 1'b0);
            if (btn_release && seen == 0) seen = i;
        end
        check("release_latency", 32'(seen), 32'(7));
        check("release_level",   32'(btn_level), 32'(0));

        // Clean press with switches at A, then switches move to 5.
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'hA, 1'b0);
        seen = 0;
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1, 4'hA, 1'b0);
            if (btn_press && seen == 0) seen = i;
        end
        check("press_latency", 32'(seen), 32'(7));
        check("press_level",   32'(btn_level), 32'(1));
        cyc(1'b1, 4'h5, 1'b0);
        cyc(1'b1, 4'h5, 1'b0);
        check("latch_sw_sync", 32'(sw_sync),    32'(4'h5));
        check("latch_held",    32'(sw_latched), 32'(4'hA));
        for (int i = 0; i < 10; i++) cyc(1'b0, 4'h5, 1'b0);

        // Bounce: 1,0,1,0 then quiet low -> nothing accepted.
        npress = 0; nlevel = 0;
        cyc(1'b1, 4'h5, 1'b0); cyc(1'b0, 4'h5, 1'b0);
        cyc(1'b1, 4'h5, 1'b0); cyc(1'b0, 4'h5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 4'h5, 1'b0);
            npress += int'(btn_press);
            nlevel += int'(btn_level);
        end
        check("bounce_press", 32'(npress), 32'(0));
        check("bounce_level", 32'(nlevel), 32'(0));

        // Reset in the middle of a pending press.
        npress = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 4'h3, 1'b0);
            npress += int'(btn_press);
        end
        check("midpress_state_before", 32'(dut.state_q), 32'(ST_PRESS_WAIT));
        cyc(1'b1, 4'h3, 1'b1);
        check("midpress_press", 32'(npress),       32'(0));
        check("midpress_state", 32'(dut.state_q),  32'(ST_IDLE));
        check("midpress_cnt",   32'(dut.cnt_q),    32'(0));
        for (int i = 0; i < 10; i++) cyc(1'b0, 4'h3, 1'b0);

        // Random bursts of varying length, occasional reset and switch change.
        rb = 1'b0; rs = '0;
        for (int n = 0; n < 120; n++) begin
            rb   = ~rb;
            hold = (($urandom % 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 12));
            if (($urandom % 4) == 0) rs = W'($urandom);
            for (int k = 0; k < hold; k++) cyc(rb, rs, (($urandom % 97) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
